// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// ps2_pkg : Set-2 scan-code constants, decoder states and event record layout
// Rev 1.0
// ============================================================================
package ps2_pkg;

   localparam logic [7:0] PS2_EXT      = 8'hE0;
   localparam logic [7:0] PS2_BRK      = 8'hF0;
   localparam logic [7:0] PS2_PAUSE    = 8'hE1;
   localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
   localparam logic [7:0] PS2_ECHO     = 8'hEE;
   localparam logic [7:0] PS2_ACK      = 8'hFA;
   localparam logic [7:0] PS2_ERR0     = 8'hFC;
   localparam logic [7:0] PS2_RESEND   = 8'hFE;
   localparam logic [7:0] PS2_NULL     = 8'h00;
   localparam logic [7:0] PS2_OVERRUN  = 8'hFF;
   localparam logic [7:0] PS2_FAKE_SH0 = 8'h12;
   localparam logic [7:0] PS2_FAKE_SH1 = 8'h59;

   localparam logic [7:0] PS2_KEY_UP    = 8'h75;
   localparam logic [7:0] PS2_KEY_DOWN  = 8'h72;
   localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
   localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;
   localparam logic [7:0] PS2_KEY_SPACE = 8'h29;

   // Bytes still to come after E1 in the 8-byte Pause sequence
   localparam logic [2:0] PAUSE_TAIL = 3'd7;
   localparam int         EVT_W      = 10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_SKIP    = 3'd4
   } ps2_state_e;

   typedef struct packed {
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } ps2_evt_t;

   function automatic logic is_status(input logic [7:0] b);
      return (b == PS2_BAT_OK) || (b == PS2_ECHO) || (b == PS2_ACK) ||
             (b == PS2_ERR0)   || (b == PS2_RESEND);
   endfunction

   function automatic logic is_fake_shift(input logic [7:0] b);
      return (b == PS2_FAKE_SH0) || (b == PS2_FAKE_SH1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
`default_nettype none
// ============================================================================
// ps2_evt_fifo : show-ahead synchronous FIFO, head read straight from storage
// Rev 1.0
// ============================================================================
module ps2_evt_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign dout  = mem_q[rd_q];

   always_comb begin
      do_pop  = pop && !empty;
      // A full FIFO still accepts a write when the head leaves in the same cycle
      do_push = push && (!full || do_pop);
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (do_push) begin
         mem_d[wr_q] = din;
         wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
         rd_d = rd_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// ps2_scancode_decoder : Set-2 byte stream to make/break events + held jog keys
// Rev 1.0
// ============================================================================
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYC = 2000000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_done,
   input  logic [7:0] rx_byte,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_break,
   output logic       key_up,
   output logic       key_down,
   output logic       key_left,
   output logic       key_right,
   output logic       key_space,
   output logic       dev_status,
   output logic       ovf,
   input  logic       ovf_clr
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   ps2_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       skip_q, skip_d;
   logic [4:0]       keys_q, keys_d;
   logic             ovf_q, ovf_d;
   logic             dev_q, dev_d;
   logic             push;
   ps2_evt_t         evt_new;
   ps2_evt_t         head;
   logic             fifo_full, fifo_empty;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      skip_d  = skip_q;
      push    = 1'b0;
      evt_new = '0;
      dev_d   = 1'b0;

      if (state_q == ST_IDLE || rx_done) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         state_d = ST_IDLE;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (rx_done) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_byte == PS2_EXT) begin
                  state_d = ST_EXT;
               end else if (rx_byte == PS2_BRK) begin
                  state_d = ST_BRK;
               end else if (rx_byte == PS2_PAUSE) begin
                  state_d = ST_SKIP;
                  skip_d  = PAUSE_TAIL;
               end else if (is_status(rx_byte)) begin
                  dev_d = 1'b1;
               end else if (rx_byte != PS2_NULL && rx_byte != PS2_OVERRUN) begin
                  push    = 1'b1;
                  evt_new = '{brk: 1'b0, ext: 1'b0, code: rx_byte};
               end
            end
            ST_EXT: begin
               if (rx_byte == PS2_BRK) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  state_d = ST_IDLE;
                  push    = !is_fake_shift(rx_byte);
                  evt_new = '{brk: 1'b0, ext: 1'b1, code: rx_byte};
               end
            end
            ST_BRK: begin
               state_d = ST_IDLE;
               push    = 1'b1;
               evt_new = '{brk: 1'b1, ext: 1'b0, code: rx_byte};
            end
            ST_EXT_BRK: begin
               state_d = ST_IDLE;
               push    = !is_fake_shift(rx_byte);
               evt_new = '{brk: 1'b1, ext: 1'b1, code: rx_byte};
            end
            ST_SKIP: begin
               if (skip_q == 3'd1) begin
                  state_d = ST_IDLE;
                  skip_d  = '0;
                  push    = 1'b1;
                  evt_new = '{brk: 1'b0, ext: 1'b0, code: PS2_PAUSE};
               end else begin
                  skip_d = skip_q - 3'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Held keys follow decoded events whether or not the FIFO had room
   always_comb begin
      keys_d = keys_q;
      if (push) begin
         case ({evt_new.ext, evt_new.code})
            {1'b1, PS2_KEY_UP}:    keys_d[0] = !evt_new.brk;
            {1'b1, PS2_KEY_DOWN}:  keys_d[1] = !evt_new.brk;
            {1'b1, PS2_KEY_LEFT}:  keys_d[2] = !evt_new.brk;
            {1'b1, PS2_KEY_RIGHT}: keys_d[3] = !evt_new.brk;
            {1'b0, PS2_KEY_SPACE}: keys_d[4] = !evt_new.brk;
            default:               keys_d    = keys_q;
         endcase
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (push && fifo_full && !evt_ready) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         skip_q  <= '0;
         keys_q  <= '0;
         ovf_q   <= 1'b0;
         dev_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         skip_q  <= skip_d;
         keys_q  <= keys_d;
         ovf_q   <= ovf_d;
         dev_q   <= dev_d;
      end
   end

   ps2_evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset_n),
      .push  (push),
      .din   (evt_new),
      .pop   (evt_ready),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign evt_valid  = !fifo_empty;
   assign evt_code   = head.code;
   assign evt_ext    = head.ext;
   assign evt_break  = head.brk;
   assign key_up     = keys_q[0];
   assign key_down   = keys_q[1];
   assign key_left   = keys_q[2];
   assign key_right  = keys_q[3];
   assign key_space  = keys_q[4];
   assign dev_status = dev_q;
   assign ovf        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// tb_ps2_scancode_decoder : directed bench with a sequence-level reference model
// Rev 1.0
// ============================================================================
module tb_ps2_scancode_decoder;

   localparam int T_CYC = 50;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx_done = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       evt_ready = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       evt_valid, evt_ext, evt_break;
   logic [7:0] evt_code;
   logic       key_up, key_down, key_left, key_right, key_space;
   logic       dev_status, ovf;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ps2_scancode_decoder #(
      .TIMEOUT_CYC (T_CYC),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx_done    (rx_done),
      .rx_byte    (rx_byte),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_code   (evt_code),
      .evt_ext    (evt_ext),
      .evt_break  (evt_break),
      .key_up     (key_up),
      .key_down   (key_down),
      .key_left   (key_left),
      .key_right  (key_right),
      .key_space  (key_space),
      .dev_status (dev_status),
      .ovf        (ovf),
      .ovf_clr    (ovf_clr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending bytes of the current sequence, events as a queue
   logic [7:0] seq[$];
   logic [9:0] mq[$];   // {brk, ext, code}
   int         gap;
   logic [4:0] mkeys;   // up, down, left, right, space in bits 0..4
   logic       movf, mdev;
   logic       emit, mpop;
   logic [9:0] ev;

   function automatic logic fake_sh(input logic [7:0] b);
      return b == 8'h12 || b == 8'h59;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seq.delete(); mq.delete();
         gap = 0; mkeys = '0; movf = 0; mdev = 0;
      end else begin
         mpop = evt_ready && (mq.size() > 0);
         emit = 0; ev = '0; mdev = 0;
         if (rx_done) begin
            gap = 0;
            seq.push_back(rx_byte);
            if (seq.size() == 1) begin
               case (seq[0])
                  8'hE0, 8'hF0, 8'hE1: ;
                  8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE: begin mdev = 1; seq.delete(); end
                  8'h00, 8'hFF: seq.delete();
                  default: begin emit = 1; ev = {2'b00, seq[0]}; seq.delete(); end
               endcase
            end else if (seq[0] == 8'hF0) begin
               emit = 1; ev = {2'b10, seq[1]}; seq.delete();
            end else if (seq[0] == 8'hE0) begin
               if (seq[1] == 8'hF0) begin
                  if (seq.size() == 3) begin
                     if (!fake_sh(seq[2])) begin emit = 1; ev = {2'b11, seq[2]}; end
                     seq.delete();
                  end
               end else begin
                  if (!fake_sh(seq[1])) begin emit = 1; ev = {2'b01, seq[1]}; end
                  seq.delete();
               end
            end else if (seq.size() == 8) begin
               emit = 1; ev = {2'b00, 8'hE1}; seq.delete();
            end
         end else if (seq.size() > 0) begin
            gap++;
            if (gap >= T_CYC) begin seq.delete(); gap = 0; end
         end
         if (mpop) void'(mq.pop_front());
         if (ovf_clr) movf = 0;
         if (emit) begin
            case (ev)
               {2'b01, 8'h75}, {2'b11, 8'h75}: mkeys[0] = !ev[9];
               {2'b01, 8'h72}, {2'b11, 8'h72}: mkeys[1] = !ev[9];
               {2'b01, 8'h6B}, {2'b11, 8'h6B}: mkeys[2] = !ev[9];
               {2'b01, 8'h74}, {2'b11, 8'h74}: mkeys[3] = !ev[9];
               {2'b00, 8'h29}, {2'b10, 8'h29}: mkeys[4] = !ev[9];
               default: ;
            endcase
            if (mq.size() < DEPTH) mq.push_back(ev);
            else movf = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         chk("cmp_valid", 32'(evt_valid), 32'(mq.size() > 0));
         if (mq.size() > 0)
            chk("cmp_head", {22'd0, evt_break, evt_ext, evt_code}, {22'd0, mq[0]});
         chk("cmp_keys", {27'd0, key_space, key_right, key_left, key_down, key_up}, {27'd0, mkeys});
         chk("cmp_ovf", 32'(ovf), 32'(movf));
         chk("cmp_dev", 32'(dev_status), 32'(mdev));
      end
   end

   task automatic send(input logic [7:0] b);
      rx_done = 1'b1; rx_byte = b;
      @(posedge clk); #2;
      rx_done = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic pop1();
      evt_ready = 1'b1;
      @(posedge clk); #2;
      evt_ready = 1'b0;
   endtask

   task automatic chk_head(input string name, input logic [7:0] code, input logic ext, input logic brk);
      chk(name, {21'd0, evt_valid, evt_break, evt_ext, evt_code}, {21'd0, 1'b1, brk, ext, code});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      idle(3);
      chk("rst_valid", 32'(evt_valid), 0);
      chk("rst_keys", {27'd0, key_space, key_right, key_left, key_down, key_up}, 0);
      chk("rst_ovf_dev", {30'd0, ovf, dev_status}, 0);
      reset_n = 1'b1;
      idle(2);

      send(8'h1C);
      chk_head("make_1c", 8'h1C, 0, 0);
      pop1();
      chk("pop_empty", 32'(evt_valid), 0);

      send(8'hE0); send(8'h75);
      chk("up_pressed", 32'(key_up), 1);
      send(8'hE0); send(8'hF0);
      chk("up_still", 32'(key_up), 1);
      send(8'h75);
      chk("up_released", 32'(key_up), 0);
      chk_head("ext_make_75", 8'h75, 1, 0);
      pop1();
      chk_head("ext_brk_75", 8'h75, 1, 1);
      pop1();

      send(8'hE0);
      idle(T_CYC + 5);
      send(8'h1C);
      chk_head("timeout_1c", 8'h1C, 0, 0);
      pop1();
      chk("timeout_one_evt", 32'(evt_valid), 0);

      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0);
      chk("pause_pending", 32'(evt_valid), 0);
      send(8'h77);
      chk_head("pause_evt", 8'hE1, 0, 0);
      chk("pause_keys", {27'd0, key_space, key_right, key_left, key_down, key_up}, 0);
      pop1();

      send(8'h15); send(8'h1D); send(8'h24);
      send(8'h2D); send(8'h2C); send(8'h35);
      chk("ovf_set", 32'(ovf), 1);
      chk_head("full_head", 8'h15, 0, 0);
      evt_ready = 1'b1;
      send(8'h3C);
      evt_ready = 1'b0;
      chk_head("push_pop_full", 8'h1D, 0, 0);
      ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
      chk("ovf_cleared", 32'(ovf), 0);
      pop1(); chk_head("fifo_order_24", 8'h24, 0, 0);
      pop1(); chk_head("fifo_order_2d", 8'h2D, 0, 0);
      pop1(); chk_head("fifo_order_3c", 8'h3C, 0, 0);
      pop1(); chk("fifo_drained", 32'(evt_valid), 0);

      send(8'hAA);
      chk("dev_pulse", {30'd0, dev_status, evt_valid}, 32'b10);
      idle(1);
      chk("dev_low", 32'(dev_status), 0);

      send(8'h29);
      chk("space_held", 32'(key_space), 1);
      pop1();
      send(8'hE0); send(8'hF0);
      reset_n = 1'b0;
      #1;
      chk("async_rst", {30'd0, key_space, evt_valid}, 0);
      idle(2);
      reset_n = 1'b1;
      idle(1);
      send(8'h6B);
      chk_head("post_rst_6b", 8'h6B, 0, 0);
      chk("post_rst_left", 32'(key_left), 0);
      pop1();
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
